// File: rtl/hazard3_fetch_ahbl.sv
// AHB-Lite instruction fetch adapter: one address phase + one data phase in flight.
// Optional macro HAZARD3_FETCH_RESP_REG_EN registers the response outputs (+1 cycle latency).
module hazard3_fetch_ahbl #(
  parameter int unsigned W_ADDR      = 32,
  parameter int unsigned W_DATA      = 32,
  parameter logic [3:0]  HPROT_FETCH = 4'b0010
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              mem_size,
  input  logic [W_ADDR-1:0] mem_addr,
  input  logic              mem_addr_vld,
  output logic              mem_addr_rdy,
  output logic [W_DATA-1:0] mem_data,
  output logic              mem_data_vld,
  output logic              mem_data_err,

  output logic [W_ADDR-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic              hwrite,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic [W_DATA-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [W_DATA-1:0] hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DPH  = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Low for the first cycle after reset release so the bus stays idle one cycle.
  logic bus_en;

  logic err_first;
  logic nonseq;
  logic accept;
  logic resp_vld;
  logic resp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      bus_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      bus_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    resp_vld  = 1'b0;
    resp_err  = 1'b0;
    err_first = (state == S_DPH) && hresp && !hready;
    nonseq    = mem_addr_vld && bus_en && !rst && (state != S_ERR2) && !err_first;
    accept    = nonseq && hready;

    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_DPH;
      end
      S_DPH: begin
        if (err_first) begin
          state_nxt = S_ERR2;
        end else if (hready) begin
          resp_vld  = !rst;
          resp_err  = hresp && !rst;
          state_nxt = accept ? S_DPH : S_IDLE;
        end
      end
      S_ERR2: begin
        resp_vld  = !rst;
        resp_err  = !rst;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address phase is a straight pass-through of the request.
  assign haddr        = mem_addr;
  assign hsize        = mem_size ? 3'd2 : 3'd1;
  assign htrans       = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign mem_addr_rdy = accept;

  assign hwrite    = 1'b0;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_FETCH;
  assign hmastlock = 1'b0;
  assign hwdata    = W_DATA'(0);

`ifdef HAZARD3_FETCH_RESP_REG_EN
  logic [W_DATA-1:0] data_q;
  logic              vld_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= W_DATA'(0);
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= resp_vld;
      err_q <= resp_err;
      if (resp_vld) data_q <= hrdata;
    end
  end

  assign mem_data     = data_q;
  assign mem_data_vld = vld_q;
  assign mem_data_err = err_q;
`else
  assign mem_data     = hrdata;
  assign mem_data_vld = resp_vld;
  assign mem_data_err = resp_err;
`endif

endmodule
